// File: rtl/wb_burst_initiator.sv
// Wishbone-classic burst initiator: turns (addr, len, we) commands into incrementing word bursts.
// Optional bus-timeout abort is enabled by defining WB_TIMEOUT_EN.
module wb_burst_initiator #(
    parameter int unsigned LEN_WIDTH = 8
`ifdef WB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [LEN_WIDTH-1:0] cmd_len_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    input  logic [31:0]          wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [31:0]          addr_o,
    output logic [31:0]          data_o,
    input  logic [31:0]          data_i,
    input  logic                 ack_i
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  wfull_q, wfull_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic in_access, stb, beat, last, timeout;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr_i[1:0];

    assign in_access = (state_q == StAccess);
    // Reads stall while the response slot is full and not draining; writes wait for data.
    assign stb  = in_access && (we_q ? wfull_q : (!rsp_valid_q || rsp_ready_i));
    assign beat = stb && ack_i;
    assign last = (rem_q == '0);

    assign cmd_ready_o   = !rst && (state_q == StIdle);
    // Never accept a word beyond the burst length.
    assign wdata_ready_o = in_access && we_q && (!wfull_q || (beat && !last));
    assign cyc_o         = in_access;
    assign stb_o         = stb;
    assign we_o          = in_access && we_q;
    assign addr_o        = addr_q;
    assign data_o        = wdata_q;
    assign busy_o        = in_access;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (stb && !ack_i) begin
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        wfull_d     = wfull_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        // Reload wins over consume so a simultaneous drain and ack keeps the slot full.
        if (beat && !we_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_i;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        if (wdata_valid_i && wdata_ready_o) begin
            wfull_d = 1'b1;
            wdata_d = wdata_i;
        end else if (beat && we_q) begin
            wfull_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d = StAccess;
                    we_d    = cmd_we_i;
                    addr_d  = {cmd_addr_i[31:2], 2'b00};
                    rem_d   = cmd_len_i;
                end
            end
            StAccess: begin
                if (timeout) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    wfull_d = 1'b0;
                end else if (beat) begin
                    addr_d = addr_q + 32'd4;
                    rem_d  = rem_q - 1'b1;
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            wfull_q     <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            wfull_q     <= wfull_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
